// File: rtl/enemy_pkg.sv
// Shared state encoding and default geometry for the enemy sequencer slice.
// Imported by the interface, the priority finder and the sequencer top.
package enemy_pkg;

  localparam int DEFAULT_X_W   = 9;
  localparam int DEFAULT_Y_W   = 8;
  localparam int DEFAULT_COL_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_GEN_DONE,
    S_DSEL,
    S_DRUN,
    S_DRAW_DONE
  } seq_state_t;

endpackage

// File: rtl/enemy_sequencer_if.sv
// Bundle between the game control / enemy instances / VGA mux and the sequencer.
// The master modport is the sequencer side; slave is the surrounding system.
interface enemy_sequencer_if
  import enemy_pkg::*;
#(
  parameter int N_ENEMIES = 3,
  parameter int X_W       = DEFAULT_X_W,
  parameter int Y_W       = DEFAULT_Y_W,
  parameter int COL_W     = DEFAULT_COL_W
);

  logic                         init;
  logic                         gen_move;
  logic                         draw;
  logic [N_ENEMIES-1:0]         kill;
  logic [N_ENEMIES*X_W-1:0]     child_x_draw;
  logic [N_ENEMIES*Y_W-1:0]     child_y_draw;
  logic [N_ENEMIES*COL_W-1:0]   child_colour;
  logic [N_ENEMIES-1:0]         child_write;
  logic [N_ENEMIES-1:0]         child_draw_done;

  logic [N_ENEMIES-1:0]         alive;
  logic [N_ENEMIES-1:0]         gen_move_en;
  logic                         gen_move_done;
  logic [N_ENEMIES-1:0]         draw_en;
  logic [X_W-1:0]               x_draw;
  logic [Y_W-1:0]               y_draw;
  logic [COL_W-1:0]             colour;
  logic                         VGA_write;
  logic                         draw_done;
  logic                         timeout;

  modport master (
    input  init, gen_move, draw, kill,
    input  child_x_draw, child_y_draw, child_colour, child_write, child_draw_done,
    output alive, gen_move_en, gen_move_done, draw_en,
    output x_draw, y_draw, colour, VGA_write, draw_done, timeout
  );

  modport slave (
    output init, gen_move, draw, kill,
    output child_x_draw, child_y_draw, child_colour, child_write, child_draw_done,
    input  alive, gen_move_en, gen_move_done, draw_en,
    input  x_draw, y_draw, colour, VGA_write, draw_done, timeout
  );

endinterface

// File: rtl/enemy_next_alive.sv
// Combinational priority finder: lowest set mask bit at or above start.
// start is one bit wider than an index so "past the last enemy" is representable.
module enemy_next_alive #(
  parameter int N_ENEMIES = 3,
  parameter int IDX_W     = 2
) (
  input  logic [N_ENEMIES-1:0] mask,
  input  logic [IDX_W:0]       start,
  output logic                 found,
  output logic [IDX_W-1:0]     index
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (mask[i] && ((IDX_W + 1)'(i) >= start)) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_sequencer.sv
// Sequences gen_move strobes across alive enemies and grants the VGA port to
// one enemy at a time, with a per-enemy draw watchdog.
module enemy_sequencer
  import enemy_pkg::*;
#(
  parameter int                   N_ENEMIES    = 3,
  parameter int                   IDX_W        = 2,
  parameter int                   X_W          = DEFAULT_X_W,
  parameter int                   Y_W          = DEFAULT_Y_W,
  parameter int                   COL_W        = DEFAULT_COL_W,
  parameter logic [N_ENEMIES-1:0] ALIVE_INIT   = '1,
  parameter int                   DRAW_TIMEOUT = 1024
) (
  input logic         clock,
  input logic         reset,
  enemy_sequencer_if.master bus
);

  localparam int             WD_W   = $clog2(DRAW_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(DRAW_TIMEOUT - 1);

  seq_state_t           state, state_nxt;
  logic [IDX_W:0]       idx, idx_nxt;
  logic [WD_W-1:0]      wdog, wdog_nxt;
  logic [N_ENEMIES-1:0] alive_q, alive_nxt;
  logic [N_ENEMIES-1:0] gen_en_q, gen_en_nxt;
  logic [N_ENEMIES-1:0] draw_en_q, draw_en_nxt;
  logic                 gen_done_q, gen_done_nxt;
  logic                 draw_done_q, draw_done_nxt;
  logic                 timeout_q, timeout_nxt;
  logic                 vga_write_q, vga_write_nxt;
  logic [X_W-1:0]       x_q, x_nxt;
  logic [Y_W-1:0]       y_q, y_nxt;
  logic [COL_W-1:0]     col_q, col_nxt;

  logic                 found;
  logic [IDX_W-1:0]     found_idx;
  logic [IDX_W-1:0]     cur;
  logic                 wd_hit;

  // Kills landing this cycle already hide their enemy from the search.
  enemy_next_alive #(
    .N_ENEMIES(N_ENEMIES),
    .IDX_W    (IDX_W)
  ) u_next (
    .mask (alive_q & ~bus.kill),
    .start(idx),
    .found(found),
    .index(found_idx)
  );

  assign cur    = idx[IDX_W-1:0];
  assign wd_hit = (wdog == WD_MAX);

  always_ff @(posedge clock) begin
    if (reset || bus.init) begin
      state       <= S_IDLE;
      idx         <= '0;
      wdog        <= '0;
      alive_q     <= ALIVE_INIT;
      gen_en_q    <= '0;
      draw_en_q   <= '0;
      gen_done_q  <= 1'b0;
      draw_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      vga_write_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      wdog        <= wdog_nxt;
      alive_q     <= alive_nxt;
      gen_en_q    <= gen_en_nxt;
      draw_en_q   <= draw_en_nxt;
      gen_done_q  <= gen_done_nxt;
      draw_done_q <= draw_done_nxt;
      timeout_q   <= timeout_nxt;
      vga_write_q <= vga_write_nxt;
      x_q         <= x_nxt;
      y_q         <= y_nxt;
      col_q       <= col_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    wdog_nxt      = wdog;
    alive_nxt     = alive_q & ~bus.kill;
    gen_en_nxt    = '0;
    draw_en_nxt   = draw_en_q;
    gen_done_nxt  = gen_done_q;
    draw_done_nxt = draw_done_q;
    timeout_nxt   = 1'b0;
    vga_write_nxt = 1'b0;
    x_nxt         = '0;
    y_nxt         = '0;
    col_nxt       = '0;

    case (state)
      S_IDLE: begin
        if (bus.gen_move) begin
          state_nxt = S_GEN;
          idx_nxt   = '0;
        end else if (bus.draw) begin
          state_nxt = S_DSEL;
          idx_nxt   = '0;
        end
      end
      S_GEN: begin
        if (found) begin
          gen_en_nxt = N_ENEMIES'(1) << found_idx;
          idx_nxt    = {1'b0, found_idx} + (IDX_W + 1)'(1);
        end else begin
          state_nxt    = S_GEN_DONE;
          gen_done_nxt = 1'b1;
        end
      end
      S_GEN_DONE: begin
        if (!bus.gen_move) begin
          state_nxt    = S_IDLE;
          gen_done_nxt = 1'b0;
        end
      end
      S_DSEL: begin
        if (found) begin
          state_nxt   = S_DRUN;
          draw_en_nxt = N_ENEMIES'(1) << found_idx;
          idx_nxt     = {1'b0, found_idx};
          wdog_nxt    = '0;
        end else begin
          state_nxt     = S_DRAW_DONE;
          draw_done_nxt = 1'b1;
        end
      end
      S_DRUN: begin
        if (bus.child_draw_done[cur] || bus.kill[cur] || wd_hit) begin
          state_nxt   = S_DSEL;
          draw_en_nxt = '0;
          idx_nxt     = idx + (IDX_W + 1)'(1);
          timeout_nxt = wd_hit && !bus.child_draw_done[cur] && !bus.kill[cur];
        end else begin
          wdog_nxt      = wdog + WD_W'(1);
          vga_write_nxt = bus.child_write[cur];
          x_nxt         = bus.child_x_draw[int'(cur) * X_W +: X_W];
          y_nxt         = bus.child_y_draw[int'(cur) * Y_W +: Y_W];
          col_nxt       = bus.child_colour[int'(cur) * COL_W +: COL_W];
        end
      end
      S_DRAW_DONE: begin
        if (!bus.draw) begin
          state_nxt     = S_IDLE;
          draw_done_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.alive         = alive_q;
  assign bus.gen_move_en   = gen_en_q;
  assign bus.gen_move_done = gen_done_q;
  assign bus.draw_en       = draw_en_q;
  assign bus.x_draw        = x_q;
  assign bus.y_draw        = y_q;
  assign bus.colour        = col_q;
  assign bus.VGA_write     = vga_write_q;
  assign bus.draw_done     = draw_done_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_enemy_sequencer.sv
// Directed bench for enemy_sequencer: three enemies, 16-cycle draw watchdog,
// hand-computed expectations sampled 1 time unit after each rising edge.
module tb_enemy_sequencer;
  import enemy_pkg::*;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  enemy_sequencer_if #(.N_ENEMIES(3), .X_W(9), .Y_W(8), .COL_W(6)) bus ();

  enemy_sequencer #(
    .N_ENEMIES   (3),
    .IDX_W       (2),
    .X_W         (9),
    .Y_W         (8),
    .COL_W       (6),
    .ALIVE_INIT  (3'b111),
    .DRAW_TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic gm, input logic dr, input logic [2:0] kl);
    bus.gen_move = gm;
    bus.draw     = dr;
    bus.kill     = kl;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setDone(input logic [2:0] d);
    bus.child_draw_done = d;
  endtask

  initial begin
    reset               = 1'b1;
    bus.init            = 1'b0;
    bus.gen_move        = 1'b0;
    bus.draw            = 1'b0;
    bus.kill            = '0;
    bus.child_x_draw    = {9'h0, 9'h1AB, 9'd5};
    bus.child_y_draw    = {8'h0, 8'h22, 8'd7};
    bus.child_colour    = {6'h0, 6'h15, 6'h3F};
    bus.child_write     = '0;
    bus.child_draw_done = '0;

    // reset state
    step();
    step();
    checkOutput("rst_alive", 32'(bus.alive), 32'h7);
    checkOutput("rst_gen_en", 32'(bus.gen_move_en), 32'h0);
    checkOutput("rst_draw_en", 32'(bus.draw_en), 32'h0);
    checkOutput("rst_gen_done", 32'(bus.gen_move_done), 32'h0);
    checkOutput("rst_draw_done", 32'(bus.draw_done), 32'h0);
    checkOutput("rst_vga", 32'(bus.VGA_write), 32'h0);
    checkOutput("rst_timeout", 32'(bus.timeout), 32'h0);
    reset = 1'b0;

    // full gen phase, all alive
    applyStimulus(1'b1, 1'b0, 3'b000);
    checkOutput("gen_t0", 32'(bus.gen_move_en), 32'h0);
    step();
    checkOutput("gen_s0", 32'(bus.gen_move_en), 32'h1);
    step();
    checkOutput("gen_s1", 32'(bus.gen_move_en), 32'h2);
    step();
    checkOutput("gen_s2", 32'(bus.gen_move_en), 32'h4);
    checkOutput("gen_done_early", 32'(bus.gen_move_done), 32'h0);
    step();
    checkOutput("gen_s3", 32'(bus.gen_move_en), 32'h0);
    checkOutput("gen_done_rise", 32'(bus.gen_move_done), 32'h1);
    step();
    checkOutput("gen_done_hold", 32'(bus.gen_move_done), 32'h1);
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("gen_done_fall", 32'(bus.gen_move_done), 32'h0);

    // kill enemy 1, then gen skips it
    applyStimulus(1'b0, 1'b0, 3'b010);
    checkOutput("kill1_alive", 32'(bus.alive), 32'h5);
    applyStimulus(1'b1, 1'b0, 3'b000);
    step();
    checkOutput("kgen_s0", 32'(bus.gen_move_en), 32'h1);
    step();
    checkOutput("kgen_s2", 32'(bus.gen_move_en), 32'h4);
    step();
    checkOutput("kgen_done", 32'(bus.gen_move_done), 32'h1);
    checkOutput("kgen_en0", 32'(bus.gen_move_en), 32'h0);
    checkOutput("kgen_alive", 32'(bus.alive), 32'h5);
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("kgen_done_fall", 32'(bus.gen_move_done), 32'h0);
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
    checkOutput("init_alive", 32'(bus.alive), 32'h7);

    // draw phase: enemy 0 writes four pixels
    applyStimulus(1'b0, 1'b1, 3'b000);
    checkOutput("dsel_en", 32'(bus.draw_en), 32'h0);
    step();
    checkOutput("d0_en", 32'(bus.draw_en), 32'h1);
    bus.child_write = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("d0_vga", 32'(bus.VGA_write), 32'h1);
      checkOutput("d0_x", 32'(bus.x_draw), 32'd5);
      checkOutput("d0_y", 32'(bus.y_draw), 32'd7);
      checkOutput("d0_col", 32'(bus.colour), 32'h3F);
    end
    bus.child_write = 3'b000;
    setDone(3'b001);
    step();
    setDone(3'b000);
    checkOutput("d0_exit_en", 32'(bus.draw_en), 32'h0);
    checkOutput("d0_exit_vga", 32'(bus.VGA_write), 32'h0);
    checkOutput("d0_exit_x", 32'(bus.x_draw), 32'h0);
    step();
    checkOutput("d1_en", 32'(bus.draw_en), 32'h2);
    step();
    checkOutput("d1_x", 32'(bus.x_draw), 32'h1AB);
    checkOutput("d1_y", 32'(bus.y_draw), 32'h22);
    checkOutput("d1_col", 32'(bus.colour), 32'h15);
    checkOutput("d1_vga", 32'(bus.VGA_write), 32'h0);
    setDone(3'b010);
    step();
    setDone(3'b000);
    checkOutput("d1_exit_en", 32'(bus.draw_en), 32'h0);
    step();
    checkOutput("d2_en", 32'(bus.draw_en), 32'h4);
    setDone(3'b100);
    step();
    setDone(3'b000);
    checkOutput("d2_no_done_yet", 32'(bus.draw_done), 32'h0);
    step();
    checkOutput("draw_done_rise", 32'(bus.draw_done), 32'h1);
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("draw_done_fall", 32'(bus.draw_done), 32'h0);

    // watchdog aborts enemy 1
    applyStimulus(1'b0, 1'b1, 3'b000);
    step();
    setDone(3'b001);
    step();
    setDone(3'b000);
    step();
    checkOutput("wd_en_start", 32'(bus.draw_en), 32'h2);
    for (int i = 0; i < 15; i++) begin
      step();
      checkOutput("wd_hold_en", 32'(bus.draw_en), 32'h2);
      checkOutput("wd_hold_to", 32'(bus.timeout), 32'h0);
    end
    step();
    checkOutput("wd_drop_en", 32'(bus.draw_en), 32'h0);
    checkOutput("wd_pulse", 32'(bus.timeout), 32'h1);
    step();
    checkOutput("wd_pulse_end", 32'(bus.timeout), 32'h0);
    checkOutput("wd_next_en", 32'(bus.draw_en), 32'h4);
    setDone(3'b100);
    step();
    setDone(3'b000);
    step();
    checkOutput("wd_draw_done", 32'(bus.draw_done), 32'h1);
    applyStimulus(1'b0, 1'b0, 3'b000);

    // kill enemy 0 while it owns the port
    applyStimulus(1'b0, 1'b1, 3'b000);
    step();
    checkOutput("k0_en", 32'(bus.draw_en), 32'h1);
    bus.child_write = 3'b001;
    step();
    checkOutput("k0_vga", 32'(bus.VGA_write), 32'h1);
    applyStimulus(1'b0, 1'b1, 3'b001);
    bus.kill = 3'b000;
    checkOutput("k0_vga_off", 32'(bus.VGA_write), 32'h0);
    checkOutput("k0_en_off", 32'(bus.draw_en), 32'h0);
    checkOutput("k0_alive", 32'(bus.alive), 32'h6);
    checkOutput("k0_to", 32'(bus.timeout), 32'h0);
    bus.child_write = 3'b000;
    step();
    checkOutput("k0_next_en", 32'(bus.draw_en), 32'h2);
    setDone(3'b010);
    step();
    setDone(3'b000);
    step();
    checkOutput("k0_en2", 32'(bus.draw_en), 32'h4);
    setDone(3'b100);
    step();
    setDone(3'b000);
    step();
    checkOutput("k0_draw_done", 32'(bus.draw_done), 32'h1);
    applyStimulus(1'b0, 1'b0, 3'b000);
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
    checkOutput("k0_init_alive", 32'(bus.alive), 32'h7);

    // gen and draw together: gen first, then draw after IDLE
    applyStimulus(1'b1, 1'b1, 3'b000);
    step();
    checkOutput("both_s0", 32'(bus.gen_move_en), 32'h1);
    checkOutput("both_no_draw", 32'(bus.draw_en), 32'h0);
    step();
    step();
    checkOutput("both_s2", 32'(bus.gen_move_en), 32'h4);
    step();
    checkOutput("both_gen_done", 32'(bus.gen_move_done), 32'h1);
    step();
    checkOutput("both_hold_en", 32'(bus.draw_en), 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b000);
    checkOutput("both_idle_done", 32'(bus.gen_move_done), 32'h0);
    checkOutput("both_idle_en", 32'(bus.draw_en), 32'h0);
    step();
    checkOutput("both_dsel_en", 32'(bus.draw_en), 32'h0);
    step();
    checkOutput("both_d0_en", 32'(bus.draw_en), 32'h1);
    bus.child_write = 3'b001;
    step();
    checkOutput("both_d0_vga", 32'(bus.VGA_write), 32'h1);

    // reset in the middle of a draw
    reset = 1'b1;
    step();
    checkOutput("mrst_vga", 32'(bus.VGA_write), 32'h0);
    checkOutput("mrst_en", 32'(bus.draw_en), 32'h0);
    checkOutput("mrst_x", 32'(bus.x_draw), 32'h0);
    checkOutput("mrst_col", 32'(bus.colour), 32'h0);
    checkOutput("mrst_alive", 32'(bus.alive), 32'h7);
    reset           = 1'b0;
    bus.draw        = 1'b0;
    bus.child_write = 3'b000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
